// File: rtl/eg2000_tape_player.sv
`default_nettype none
// ============================================================================
// Module   : eg2000_tape_player
// Purpose  : Cassette transmitter for the Colour Genie core. Serialises host
//            bytes (MSB first) into the FM tape waveform that the cassette
//            loader reads back on the EAR input. Every bit cell starts with a
//            low clock pulse; a 1 bit adds a second low pulse at mid-cell.
//            All waveform timing advances on the i_ce strobe; the byte
//            handshake runs on every clock.
// Ports    : i_clk      system clock
//            i_rst_n    synchronous active-low reset
//            i_ce       timing enable strobe (one clock wide)
//            i_play     motor/play enable, low = stop at end of current cell
//            i_data     byte to transmit
//            i_valid    i_data is valid
//            o_ready    holding register empty; byte taken on valid & ready
//            o_busy     a byte is being shifted out
//            o_ear      tape waveform, idle 1, pulses 0
//            o_underrun one-clock pulse when a byte ends with nothing queued
// Options  : TAPE_LEADER_EN - when defined, each start from idle is preceded
//            by LEADER bytes of 0xAA and a 0x66 sync byte.
// Revision : 1.0 - initial release
// ============================================================================
module eg2000_tape_player #(
    parameter int CELL   = 1848,  // bit-cell length in ce ticks
    parameter int PULSE  = 220,   // low pulse width, 0 < PULSE < CELL/2
    parameter int LEADER = 255    // leader byte count (TAPE_LEADER_EN only)
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ce,
    input  logic       i_play,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_ear,
    output logic       o_underrun
);

    localparam int TW = $clog2(CELL);

    // Last tick of each phase inside a cell.
    localparam logic [TW-1:0] c_pulse_last = TW'(PULSE - 1);
    localparam logic [TW-1:0] c_half_last  = TW'(CELL / 2 - 1);
    localparam logic [TW-1:0] c_data_last  = TW'(CELL / 2 + PULSE - 1);
    localparam logic [TW-1:0] c_cell_last  = TW'(CELL - 1);
    localparam logic [TW-1:0] c_tick_one   = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CLK_PULSE  = 3'd1,
        S_GAP1       = 3'd2,
        S_DATA_PULSE = 3'd3,
        S_GAP2       = 3'd4
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_tick;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic [7:0]      r_hold;
    logic            r_full;
    logic            r_ear;
    logic            r_busy;
    logic            r_underrun;
`ifdef TAPE_LEADER_EN
    logic [7:0]      r_lead_cnt;   // leader bytes still to send after current
    logic            r_sync_pend;  // sync byte not yet sent
    logic            r_pre;        // preamble (leader + sync) in progress
`endif

    logic w_accept;

    // The holding register stays full throughout the preamble, so ready is
    // naturally held low until the queued byte is finally loaded.
    assign w_accept   = i_valid & ~r_full;
    assign o_ready    = ~r_full;
    assign o_busy     = r_busy;
    assign o_ear      = r_ear;
    assign o_underrun = r_underrun;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_tick     <= '0;
            r_bitcnt   <= 3'd0;
            r_shift    <= 8'd0;
            r_hold     <= 8'd0;
            r_full     <= 1'b0;
            r_ear      <= 1'b1;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
`ifdef TAPE_LEADER_EN
            r_lead_cnt  <= 8'd0;
            r_sync_pend <= 1'b0;
            r_pre       <= 1'b0;
`endif
        end else begin
            r_underrun <= 1'b0;
            if (i_ce) begin
                case (r_state)
                    S_IDLE: begin
                        if (r_full && i_play) begin
`ifdef TAPE_LEADER_EN
                            r_pre <= 1'b1;
                            if (LEADER > 0) begin
                                r_shift     <= 8'hAA;
                                r_lead_cnt  <= 8'(LEADER - 1);
                                r_sync_pend <= 1'b1;
                            end else begin
                                r_shift     <= 8'h66;
                                r_lead_cnt  <= 8'd0;
                                r_sync_pend <= 1'b0;
                            end
`else
                            r_shift <= r_hold;
                            r_full  <= 1'b0;
`endif
                            r_tick   <= '0;
                            r_bitcnt <= 3'd0;
                            r_busy   <= 1'b1;
                            r_ear    <= 1'b0;  // clock pulse starts at tick 0
                            r_state  <= S_CLK_PULSE;
                        end
                    end
                    S_CLK_PULSE: begin
                        r_tick <= r_tick + c_tick_one;
                        if (r_tick == c_pulse_last) begin
                            r_ear   <= 1'b1;
                            r_state <= S_GAP1;
                        end
                    end
                    S_GAP1: begin
                        r_tick <= r_tick + c_tick_one;
                        if (r_tick == c_half_last) begin
                            // A 0 bit keeps the line high through this phase.
                            r_ear   <= ~r_shift[7];
                            r_state <= S_DATA_PULSE;
                        end
                    end
                    S_DATA_PULSE: begin
                        r_tick <= r_tick + c_tick_one;
                        if (r_tick == c_data_last) begin
                            r_ear   <= 1'b1;
                            r_state <= S_GAP2;
                        end
                    end
                    S_GAP2: begin
                        if (r_tick != c_cell_last) begin
                            r_tick <= r_tick + c_tick_one;
                        end else if (!i_play) begin
                            // Stop at the cell boundary; rest of the byte is
                            // dropped but the queued byte is kept.
                            r_tick   <= '0;
                            r_bitcnt <= 3'd0;
                            r_busy   <= 1'b0;
                            r_ear    <= 1'b1;
                            r_state  <= S_IDLE;
`ifdef TAPE_LEADER_EN
                            r_pre    <= 1'b0;
`endif
                        end else if (r_bitcnt != 3'd7) begin
                            r_tick   <= '0;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_ear    <= 1'b0;
                            r_state  <= S_CLK_PULSE;
`ifdef TAPE_LEADER_EN
                        end else if (r_pre) begin
                            r_tick   <= '0;
                            r_bitcnt <= 3'd0;
                            r_ear    <= 1'b0;
                            r_state  <= S_CLK_PULSE;
                            if (r_lead_cnt != 8'd0) begin
                                r_shift    <= 8'hAA;
                                r_lead_cnt <= r_lead_cnt - 8'd1;
                            end else if (r_sync_pend) begin
                                r_shift     <= 8'h66;
                                r_sync_pend <= 1'b0;
                            end else begin
                                r_shift <= r_hold;
                                r_full  <= 1'b0;
                                r_pre   <= 1'b0;
                            end
`endif
                        end else if (r_full) begin
                            // Back-to-back: next byte's clock pulse follows
                            // immediately with no idle cell.
                            r_tick   <= '0;
                            r_bitcnt <= 3'd0;
                            r_shift  <= r_hold;
                            r_full   <= 1'b0;
                            r_ear    <= 1'b0;
                            r_state  <= S_CLK_PULSE;
                        end else begin
                            r_tick     <= '0;
                            r_bitcnt   <= 3'd0;
                            r_busy     <= 1'b0;
                            r_ear      <= 1'b1;
                            r_underrun <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_ear   <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
            // Accept comes last so a same-clock load and accept leaves the
            // holding register full with the new byte.
            if (w_accept) begin
                r_hold <= i_data;
                r_full <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eg2000_tape_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_eg2000_tape_player
// Purpose  : Self-checking bench for eg2000_tape_player. A byte/cell level
//            reference model predicts ear, ready, busy and underrun after
//            every clock; directed sequences plus randomized traffic.
//            Honours TAPE_LEADER_EN when defined for the whole build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eg2000_tape_player;

    localparam int CELL   = 16;
    localparam int PULSE  = 2;
    localparam int LEADER = 4;
`ifdef TAPE_LEADER_EN
    localparam int PRE_BYTES = LEADER + 1;
    localparam logic [7:0] c_first = 8'h3C;
`else
    localparam int PRE_BYTES = 0;
    localparam logic [7:0] c_first = 8'hA5;
`endif
    localparam int BYTE_CE = 8 * CELL;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic       play = 1'b0;
    logic [7:0] data = 8'd0;
    logic       valid = 1'b0;
    logic       ready, busy, ear, underrun;

    int n_checks = 0;
    int n_errors = 0;

    eg2000_tape_player #(.CELL(CELL), .PULSE(PULSE), .LEADER(LEADER)) u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_ce       (ce),
        .i_play     (play),
        .i_data     (data),
        .i_valid    (valid),
        .o_ready    (ready),
        .o_busy     (busy),
        .o_ear      (ear),
        .o_underrun (underrun)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (bytes, bit index, cell position) ----
    bit         m_full   = 1'b0;
    logic [7:0] m_hold   = 8'd0;
    bit         m_active = 1'b0;
    logic [7:0] m_cur    = 8'd0;
    int         m_nbit   = 0;
    int         m_pos    = 0;
    bit         m_under  = 1'b0;
    logic [7:0] m_pre[$];

    function automatic bit m_ear();
        bit b;
        if (!m_active) return 1'b1;
        b = m_cur[7 - m_nbit];
        return !((m_pos < PULSE) ||
                 (b && m_pos >= CELL / 2 && m_pos < CELL / 2 + PULSE));
    endfunction

    task automatic m_start();
`ifdef TAPE_LEADER_EN
        for (int k = 0; k < LEADER; k++) m_pre.push_back(8'hAA);
        m_pre.push_back(8'h66);
        m_cur = m_pre.pop_front();
`else
        m_cur  = m_hold;
        m_full = 1'b0;
`endif
        m_active = 1'b1;
        m_nbit   = 0;
        m_pos    = 0;
    endtask

    task automatic m_update(input bit rn, input bit c, input bit p,
                            input bit v, input logic [7:0] d);
        bit acc;
        if (!rn) begin
            m_full = 1'b0; m_active = 1'b0; m_under = 1'b0; m_pre.delete();
            return;
        end
        acc     = v && !m_full;
        m_under = 1'b0;
        if (c) begin
            if (!m_active) begin
                if (m_full && p) m_start();
            end else if (m_pos == CELL - 1) begin
                if (!p) begin
                    m_active = 1'b0; m_pre.delete();
                end else if (m_nbit < 7) begin
                    m_nbit++; m_pos = 0;
                end else if (m_pre.size() > 0) begin
                    m_cur = m_pre.pop_front(); m_nbit = 0; m_pos = 0;
                end else if (m_full) begin
                    m_cur = m_hold; m_full = 1'b0; m_nbit = 0; m_pos = 0;
                end else begin
                    m_active = 1'b0; m_under = 1'b1;
                end
            end else begin
                m_pos++;
            end
        end
        if (acc) begin
            m_hold = d; m_full = 1'b1;
        end
    endtask

    // ---------------- checking and stimulus --------------------------------
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rn, input bit c, input bit p,
                        input bit v, input logic [7:0] d);
        @(negedge clk);
        rst_n = rn; ce = c; play = p; valid = v; data = d;
        @(posedge clk);
        m_update(rn, c, p, v, d);
        #1;
        check("ear", 32'(ear), 32'(m_ear()));
        check("ready", 32'(ready), 32'(!m_full));
        check("busy", 32'(busy), 32'(m_active));
        check("underrun", 32'(underrun), 32'(m_under));
    endtask

    int  hit;
    int  fall;
    bit  seen;
    bit  prev_busy;
    bit  sent2;

    initial begin
        // Reset held with valid high must not accept anything.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A);
        check("rst_ear", 32'(ear), 32'd1);
        check("rst_ready", 32'(ready), 32'd1);

        // Single byte, ce every clock.
        step(1'b1, 1'b0, 1'b1, 1'b1, c_first);
        check("single_ready_drop", 32'(ready), 32'd0);
        hit = -1;
        for (int i = 0; i < (PRE_BYTES + 2) * BYTE_CE && hit < 0; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
            if (underrun) hit = i;
        end
        check("single_underrun_ce", 32'(hit), 32'((PRE_BYTES + 1) * BYTE_CE));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        check("single_idle_ear", 32'(ear), 32'd1);

        // Back-to-back 0xFF then 0x00.
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
        hit = -1; sent2 = 1'b0;
        for (int i = 0; i < (PRE_BYTES + 3) * BYTE_CE && hit < 0; i++) begin
            bit v;
            v = !sent2;
            if (v && !m_full) sent2 = 1'b1;
            step(1'b1, 1'b1, 1'b1, v, 8'h00);
            if (i == (PRE_BYTES + 1) * BYTE_CE)
                check("b2b_no_gap_ear", 32'(ear), 32'd0);
            if (underrun) hit = i;
        end
        check("b2b_underrun_ce", 32'(hit), 32'((PRE_BYTES + 2) * BYTE_CE));
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);

        // Play dropped during bit 3 of 0xF0.
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'hF0);
        fall = -1; seen = 1'b0; prev_busy = 1'b0;
        for (int i = 0; i < 6 * CELL; i++) begin
            step(1'b1, 1'b1, (i < 3 * CELL + 5), 1'b0, 8'h00);
            if (prev_busy && !busy && fall < 0) fall = i;
            if (underrun) seen = 1'b1;
            prev_busy = busy;
        end
        check("drop_busy_fall_ce", 32'(fall), 32'(4 * CELL));
        check("drop_no_underrun", 32'(seen), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h81);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("drop_queued_ready", 32'(ready), 32'd0);
        hit = -1;
        for (int i = 0; i < (PRE_BYTES + 2) * BYTE_CE && hit < 0; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
            if (underrun) hit = i;
        end
        check("resume_underrun_ce", 32'(hit), 32'((PRE_BYTES + 1) * BYTE_CE));

        // Reset during a data pulse (first bit of 0xFF / 0xAA is 1).
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
        for (int i = 0; i <= CELL / 2 + 1; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        check("midcell_ear_low", 32'(ear), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        check("midcell_rst_ear", 32'(ear), 32'd1);
        check("midcell_rst_ready", 32'(ready), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);

        // Randomized traffic: sparse ce, random valid/data, play drops.
        begin
            int play_off = 0;
            for (int i = 0; i < 6000; i++) begin
                bit c, v;
                if (play_off > 0) play_off--;
                else if ($urandom_range(0, 299) == 0) play_off = $urandom_range(5, 60);
                c = ($urandom_range(0, 3) != 0);
                v = ($urandom_range(0, 2) == 0);
                step(($urandom_range(0, 2999) != 0), c, (play_off == 0), v,
                     8'($urandom_range(0, 255)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
